fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the async FIFO between NReq requesters in the write clock domain.
//  - Arbitration: round-robin with burst locking.
//  - Gating: writes are gated by the FIFO full flag.
//  - Placement: sits directly in front of the FIFO write pointer/memory logic.
//  - Status: grant state and a saturating full-stall counter.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the single write port of the async FIFO between NReq requesters.
// Round-robin arbitration with burst locking: a granted requester keeps the
// port until it signals last, drops valid, or hits MaxBurst beats. One IDLE
// cycle always separates bursts. Writes are gated by the registered full
// flag, and cycles spent stalled on full are counted (saturating).

module fifo_wr_arbiter #(
   parameter int NReq      = 4,
   parameter int DataWidth = 8,
   parameter int MaxBurst  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NReq-1:0]           i_valid,
   input  logic [NReq*DataWidth-1:0] i_data,
   input  logic [NReq-1:0]           i_last,
   output logic [NReq-1:0]           o_ready,
   input  logic                      i_full,
   output logic                      o_wr_en,
   output logic [DataWidth-1:0]      o_wr_data,
   output logic [NReq-1:0]           o_grant,
   output logic                      o_busy,
   output logic [15:0]               o_stall_cnt
);

   localparam int IdxW  = (NReq > 1) ? $clog2(NReq) : 1;
   localparam int BeatW = $clog2(MaxBurst) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [IdxW-1:0]   rr_ptr, rr_nx;
   logic [BeatW-1:0]  beat_cnt, beat_nx;
   logic [NReq-1:0]   grant, grant_nx;
   logic [15:0]       stall_cnt, stall_nx;

   logic              pick_found;
   logic [IdxW-1:0]   pick_idx;
   logic [IdxW-1:0]   cand;
   logic              accept;
   logic [DataWidth-1:0] wr_data_mux;

   // Round-robin search: first valid requester after the last granted index
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = rr_ptr;
      for (int k = 0; k < NReq; k++) begin
         cand = (cand == IdxW'(NReq - 1)) ? '0 : cand + 1'b1;
         if (!pick_found && i_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state logic: grant on IDLE, accept/stall/release while in BURST
   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      beat_nx  = beat_cnt;
      grant_nx = grant;
      stall_nx = stall_cnt;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nx           = BURST;
               rr_nx              = pick_idx;
               beat_nx            = '0;
               grant_nx           = '0;
               grant_nx[pick_idx] = 1'b1;
            end
         end
         BURST: begin
            accept = i_valid[rr_ptr] & ~i_full;
            if (!i_valid[rr_ptr]) begin
               state_nx = IDLE;
               grant_nx = '0;
               beat_nx  = '0;
            end else if (i_full) begin
               if (stall_cnt != 16'hFFFF) begin
                  stall_nx = stall_cnt + 16'd1;
               end
            end else if (i_last[rr_ptr] || (beat_cnt == BeatW'(MaxBurst - 1))) begin
               state_nx = IDLE;
               grant_nx = '0;
               beat_nx  = '0;
            end else begin
               beat_nx = beat_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
         end
      endcase
   end

   // Per-requester ready and write-data select from the granted index
   always_comb begin
      o_ready     = '0;
      wr_data_mux = '0;
      for (int k = 0; k < NReq; k++) begin
         o_ready[k] = accept && (rr_ptr == IdxW'(k));
         if (rr_ptr == IdxW'(k)) begin
            wr_data_mux = i_data[k*DataWidth +: DataWidth];
         end
      end
   end

   // State register; reset aborts any burst and restarts arbitration at req 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= IdxW'(NReq - 1);
         beat_cnt  <= '0;
         grant     <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nx;
         rr_ptr    <= rr_nx;
         beat_cnt  <= beat_nx;
         grant     <= grant_nx;
         stall_cnt <= stall_nx;
      end
   end

   assign o_wr_en     = accept;
   assign o_wr_data   = wr_data_mux;
   assign o_grant     = grant;
   assign o_busy      = (state == BURST);
   assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Table-driven check of the FIFO write arbiter: single-requester burst,
// round-robin rotation, burst cap, full stall, drop-out and async reset.

module tb_fifo_wr_arbiter;

   localparam int NReq      = 4;
   localparam int DataWidth = 8;
   localparam int MaxBurst  = 4;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        full;
      logic [31:0] data;
      logic [3:0]  exp_ready;
      logic        exp_wr_en;
      logic [7:0]  exp_wr_data;
      logic [3:0]  exp_grant;
      logic        exp_busy;
      logic [15:0] exp_stall;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [3:0]  i_valid;
   logic [31:0] i_data;
   logic [3:0]  i_last;
   logic        i_full;
   logic [3:0]  o_ready;
   logic        o_wr_en;
   logic [7:0]  o_wr_data;
   logic [3:0]  o_grant;
   logic        o_busy;
   logic [15:0] o_stall_cnt;

   int vectors_applied = 0;
   int miscompares     = 0;
   vec_t vecs[$];

   fifo_wr_arbiter #(
      .NReq      (NReq),
      .DataWidth (DataWidth),
      .MaxBurst  (MaxBurst)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .i_last      (i_last),
      .o_ready     (o_ready),
      .i_full      (i_full),
      .o_wr_en     (o_wr_en),
      .o_wr_data   (o_wr_data),
      .o_grant     (o_grant),
      .o_busy      (o_busy),
      .o_stall_cnt (o_stall_cnt)
   );

   // Free-running write-domain clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last,
                               input logic full, input logic [31:0] data,
                               input logic [3:0] rdy, input logic wen,
                               input logic [7:0] wdat, input logic [3:0] gnt,
                               input logic busy, input logic [15:0] stall);
      vec_t v;
      v.valid = valid; v.last = last; v.full = full; v.data = data;
      v.exp_ready = rdy; v.exp_wr_en = wen; v.exp_wr_data = wdat;
      v.exp_grant = gnt; v.exp_busy = busy; v.exp_stall = stall;
      return v;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      i_valid = v.valid;
      i_last  = v.last;
      i_full  = v.full;
      i_data  = v.data;
   endtask

   task automatic check_output(input vec_t v, input string name);
      vectors_applied++;
      if (o_ready !== v.exp_ready) begin
         miscompares++;
         $display("[TB] FAIL %s ready: got %b want %b", name, o_ready, v.exp_ready);
      end
      if (o_wr_en !== v.exp_wr_en) begin
         miscompares++;
         $display("[TB] FAIL %s wr_en: got %b want %b", name, o_wr_en, v.exp_wr_en);
      end
      if (v.exp_wr_en && (o_wr_data !== v.exp_wr_data)) begin
         miscompares++;
         $display("[TB] FAIL %s wr_data: got %h want %h", name, o_wr_data, v.exp_wr_data);
      end
      if (o_grant !== v.exp_grant) begin
         miscompares++;
         $display("[TB] FAIL %s grant: got %b want %b", name, o_grant, v.exp_grant);
      end
      if (o_busy !== v.exp_busy) begin
         miscompares++;
         $display("[TB] FAIL %s busy: got %b want %b", name, o_busy, v.exp_busy);
      end
      if (o_stall_cnt !== v.exp_stall) begin
         miscompares++;
         $display("[TB] FAIL %s stall_cnt: got %0d want %0d", name, o_stall_cnt, v.exp_stall);
      end
   endtask

   // Main sequence: reset, vector table, then async reset mid-burst
   initial begin
      // single requester 0, three beats, last on the third
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 32'h10, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 32'h10, 4'b0001, 1, 8'h10, 4'b0001, 1, 0));
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 32'h11, 4'b0001, 1, 8'h11, 4'b0001, 1, 0));
      vecs.push_back(mk(4'b0001, 4'b0001, 0, 32'h12, 4'b0001, 1, 8'h12, 4'b0001, 1, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      // round-robin, all valid, last every beat; rr_ptr=0 so order 1,2,3,0
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0010, 1, 8'hA1, 4'b0010, 1, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0100, 1, 8'hA2, 4'b0100, 1, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b1000, 1, 8'hA3, 4'b1000, 1, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b1111, 4'b1111, 0, 32'hA3A2A1A0, 4'b0001, 1, 8'hA0, 4'b0001, 1, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      // burst cap: req 2 streams without last while req 0 waits
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B000C0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B000C0, 4'b0100, 1, 8'hB0, 4'b0100, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B100C0, 4'b0100, 1, 8'hB1, 4'b0100, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B200C0, 4'b0100, 1, 8'hB2, 4'b0100, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B300C0, 4'b0100, 1, 8'hB3, 4'b0100, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0001, 0, 32'h00B400C0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b0101, 4'b0001, 0, 32'h00B400C0, 4'b0001, 1, 8'hC0, 4'b0001, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B400C0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B400C0, 4'b0100, 1, 8'hB4, 4'b0100, 1, 0));
      // full stall for five cycles mid-burst
      vecs.push_back(mk(4'b0101, 4'b0000, 1, 32'h00B500C0, 4'b0000, 0, 8'h00, 4'b0100, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0000, 1, 32'h00B500C0, 4'b0000, 0, 8'h00, 4'b0100, 1, 1));
      vecs.push_back(mk(4'b0101, 4'b0000, 1, 32'h00B500C0, 4'b0000, 0, 8'h00, 4'b0100, 1, 2));
      vecs.push_back(mk(4'b0101, 4'b0000, 1, 32'h00B500C0, 4'b0000, 0, 8'h00, 4'b0100, 1, 3));
      vecs.push_back(mk(4'b0101, 4'b0000, 1, 32'h00B500C0, 4'b0000, 0, 8'h00, 4'b0100, 1, 4));
      // last on non-granted req 0 must not end the burst
      vecs.push_back(mk(4'b0101, 4'b0001, 0, 32'h00B500C0, 4'b0100, 1, 8'hB5, 4'b0100, 1, 5));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B600C0, 4'b0100, 1, 8'hB6, 4'b0100, 1, 5));
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 32'h00B700C0, 4'b0100, 1, 8'hB7, 4'b0100, 1, 5));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 5));
      // drop-out: req 1 deasserts valid after one beat
      vecs.push_back(mk(4'b0010, 4'b0000, 0, 32'h0000D100, 4'b0000, 0, 8'h00, 4'b0000, 0, 5));
      vecs.push_back(mk(4'b0010, 4'b0000, 0, 32'h0000D100, 4'b0010, 1, 8'hD1, 4'b0010, 1, 5));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 32'h0000D100, 4'b0000, 0, 8'h00, 4'b0010, 1, 5));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 5));

      rst     = 1'b1;
      i_valid = '0;
      i_last  = '0;
      i_full  = 1'b0;
      i_data  = '0;
      repeat (2) @(negedge clk);
      #1;
      check_output(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 0), "reset");
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         apply_stimulus(vecs[i]);
         #1;
         check_output(vecs[i], $sformatf("vec%0d", i));
      end

      // async reset mid-burst on req 2, then req 0 must win the next arbitration
      @(negedge clk);
      apply_stimulus(mk(4'b0100, 4'b0000, 0, 32'h00E200C5, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      @(negedge clk);
      #1;
      check_output(mk(4'b0100, 4'b0000, 0, 32'h00E200C5, 4'b0100, 1, 8'hE2, 4'b0100, 1, 5), "pre_rst");
      #1 rst = 1'b1;
      #1;
      check_output(mk(4'b0100, 4'b0000, 0, 32'h00E200C5, 4'b0000, 0, 8'h00, 4'b0000, 0, 0), "in_rst");
      #1;
      rst = 1'b0;
      apply_stimulus(mk(4'b1101, 4'b0001, 0, 32'h00E200C5, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      @(negedge clk);
      #1;
      check_output(mk(4'b1101, 4'b0001, 0, 32'h00E200C5, 4'b0001, 1, 8'hC5, 4'b0001, 1, 0), "post_rst");
      apply_stimulus(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
      @(negedge clk);
      #1;
      check_output(mk(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0, 0), "post_rst_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
